// File: rtl/cp0_param.sv
// cp0_param: parametrised MIPS CP0 register file with Count prescaler, Compare timer and interrupt synchroniser
module cp0_param #(
   parameter int          INT_NUM      = 5,
   parameter int          SYNC_STAGES  = 2,
   parameter int          COUNT_DIV    = 2,
   parameter logic [31:0] STATUS_WMASK = 32'h1040_FF03
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we_i,
   input  logic [4:0]         waddr_i,
   input  logic [4:0]         raddr_i,
   input  logic [31:0]        data_i,
   input  logic [INT_NUM-1:0] int_i,
   input  logic               exc_valid_i,
   input  logic [4:0]         exc_code_i,
   input  logic               eret_i,
   input  logic [31:0]        pc_i,
   input  logic               is_in_delayslot_i,
   input  logic               badaddr_we_i,
   input  logic [31:0]        bad_addr_i,
   output logic [31:0]        data_o,
   output logic [31:0]        count_o,
   output logic [31:0]        compare_o,
   output logic [31:0]        status_o,
   output logic [31:0]        cause_o,
   output logic [31:0]        epc_o,
   output logic [31:0]        config_o,
   output logic [31:0]        badvaddr_o,
   output logic               timer_int_o,
   output logic               int_req_o
);
   localparam int          PW          = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
   localparam logic [31:0] CAUSE_WMASK = 32'h0080_0300;
   logic [PW-1:0]      presc;
   logic               armed;
   logic [INT_NUM-1:0] int_s;
   logic [4:0]         ip_hw;
   logic               wrap, exl, enter;
   logic               wr_bad, wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_config;
   logic [31:0]        status_n, cause_n, epc_n, bad_n;

   assign wrap       = presc == PW'(COUNT_DIV - 1);
   assign exl        = status_o[1];
   assign enter      = exc_valid_i && !exl;
   assign ip_hw      = 5'(int_s);
   assign wr_bad     = we_i && waddr_i == 5'd8;
   assign wr_count   = we_i && waddr_i == 5'd9;
   assign wr_compare = we_i && waddr_i == 5'd11;
   assign wr_status  = we_i && waddr_i == 5'd12;
   assign wr_cause   = we_i && waddr_i == 5'd13;
   assign wr_epc     = we_i && waddr_i == 5'd14;
   assign wr_config  = we_i && waddr_i == 5'd16;
   assign int_req_o  = status_o[0] & ~status_o[1] & |(cause_o[15:8] & status_o[15:8]);

   generate
      if (SYNC_STAGES == 0) begin : g_direct
         assign int_s = int_i;
      end else begin : g_sync
         logic [INT_NUM-1:0] q [SYNC_STAGES];
         always_ff @(posedge clk) begin
            if (!rst) begin
               for (int i = 0; i < SYNC_STAGES; i++) q[i] <= '0;
            end else begin
               q[0] <= int_i;
               for (int i = 1; i < SYNC_STAGES; i++) q[i] <= q[i-1];
            end
         end
         assign int_s = q[SYNC_STAGES-1];
      end
   endgenerate

   always_comb begin
      status_n        = wr_status ? (status_o & ~STATUS_WMASK) | (data_i & STATUS_WMASK) : status_o;
      status_n[1]     = exc_valid_i ? 1'b1 : eret_i ? 1'b0 : status_n[1];
      cause_n         = wr_cause ? (cause_o & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK) : cause_o;
      cause_n[15:10]  = {timer_int_o, ip_hw};
      cause_n[6:2]    = exc_valid_i ? exc_code_i : cause_n[6:2];
      cause_n[31]     = enter ? is_in_delayslot_i : cause_n[31];
      epc_n           = enter ? (is_in_delayslot_i ? pc_i - 32'd4 : pc_i) : wr_epc ? data_i : epc_o;
      bad_n           = exc_valid_i && badaddr_we_i ? bad_addr_i : wr_bad ? data_i : badvaddr_o;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         presc       <= '0;
         count_o     <= '0;
         compare_o   <= '0;
         armed       <= 1'b0;
         timer_int_o <= 1'b0;
         status_o    <= 32'h1000_0000;
         cause_o     <= '0;
         epc_o       <= '0;
         config_o    <= 32'h0000_8000;
         badvaddr_o  <= '0;
      end else begin
         presc       <= wr_count || wrap ? '0 : presc + 1'b1;
         count_o     <= wr_count ? data_i : wrap ? count_o + 32'd1 : count_o;
         compare_o   <= wr_compare ? data_i : compare_o;
         armed       <= armed | wr_compare;
         timer_int_o <= wr_compare ? 1'b0 : armed && count_o == compare_o ? 1'b1 : timer_int_o;
         status_o    <= status_n;
         cause_o     <= cause_n;
         epc_o       <= epc_n;
         config_o    <= wr_config ? data_i : config_o;
         badvaddr_o  <= bad_n;
      end
   end

   always_comb begin
      data_o = '0;
      if (rst) begin
         case (raddr_i)
            5'd8:    data_o = badvaddr_o;
            5'd9:    data_o = count_o;
            5'd11:   data_o = compare_o;
            5'd12:   data_o = status_o;
            5'd13:   data_o = cause_o;
            5'd14:   data_o = epc_o;
            5'd16:   data_o = config_o;
            default: data_o = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_cp0_param.sv
// tb_cp0_param: directed and randomized checks of cp0_param against a behavioural model
module tb_cp0_param;
   localparam logic [31:0] SW = 32'h1040_FF03;
   logic        clk = 1'b0;
   logic        rst, we, exc, eret, dslot, bad_we;
   logic [4:0]  waddr, raddr, code;
   logic [31:0] data, pc, bad_addr;
   logic [4:0]  intr;
   logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, badvaddr_o;
   logic        timer_int_o, int_req_o;
   int          ntotal = 0, nbad = 0;
   logic [31:0] ms, mc, me, mb, mcmp, mbase;
   int          t;
   logic [4:0]  wtab [7] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd20};
   logic [4:0]  rtab [10] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd16, 5'd3, 5'd0, 5'd31};

   cp0_param #(.INT_NUM(5), .SYNC_STAGES(2), .COUNT_DIV(3), .STATUS_WMASK(SW)) dut (
      .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .raddr_i(raddr), .data_i(data),
      .int_i(intr), .exc_valid_i(exc), .exc_code_i(code), .eret_i(eret), .pc_i(pc),
      .is_in_delayslot_i(dslot), .badaddr_we_i(bad_we), .bad_addr_i(bad_addr),
      .data_o(data_o), .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
      .cause_o(cause_o), .epc_o(epc_o), .config_o(config_o), .badvaddr_o(badvaddr_o),
      .timer_int_o(timer_int_o), .int_req_o(int_req_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) else begin
         nbad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; waddr = a; data = d;
      tick(1);
      we = 1'b0;
   endtask

   function automatic logic [31:0] mread(input logic [4:0] a);
      case (a)
         5'd8:    return mb;
         5'd9:    return mbase + 32'(t / 3);
         5'd11:   return mcmp;
         5'd12:   return ms;
         5'd13:   return mc;
         5'd14:   return me;
         5'd16:   return 32'h0000_8000;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic mirq();
      return ms[0] & ~ms[1] & |(mc[15:8] & ms[15:8]);
   endfunction

   task automatic model_step();
      logic was_exl;
      was_exl = ms[1];
      if (we && waddr == 5'd9) begin
         mbase = data;
         t = 0;
      end else t++;
      if (we && waddr == 5'd11) mcmp = data;
      if (we && waddr == 5'd12) ms = (ms & ~SW) | (data & SW);
      if (we && waddr == 5'd13) mc = (mc & ~32'h0080_0300) | (data & 32'h0080_0300);
      if (we && waddr == 5'd14) me = data;
      if (exc) begin
         mc[6:2] = code;
         if (!was_exl) begin
            me = dslot ? pc - 32'd4 : pc;
            mc[31] = dslot;
         end
         ms[1] = 1'b1;
         if (bad_we) mb = bad_addr;
      end else if (eret) ms[1] = 1'b0;
   endtask

   initial begin
      rst = 1'b0; we = 1'b0; exc = 1'b0; eret = 1'b0; dslot = 1'b0; bad_we = 1'b0;
      waddr = '0; raddr = 5'd12; code = '0; data = '0; pc = '0; bad_addr = '0; intr = '0;
      tick(2);
      chk("rst_count", count_o, 32'h0);
      chk("rst_status", status_o, 32'h1000_0000);
      chk("rst_config", config_o, 32'h0000_8000);
      chk("rst_cause", cause_o, 32'h0);
      chk("rst_timer", timer_int_o, 1'b0);
      chk("rst_data", data_o, 32'h0);
      rst = 1'b1;
      tick(9);
      chk("prescale_9", count_o, 32'd3);
      mtc0(5'd9, 32'hFFFF_FFFF);
      chk("count_load", count_o, 32'hFFFF_FFFF);
      tick(3);
      chk("count_wrap", count_o, 32'h0);
      mtc0(5'd9, 32'h0);
      mtc0(5'd11, 32'h0);
      chk("cmp_wr_timer", timer_int_o, 1'b0);
      tick(1);
      chk("timer_set", timer_int_o, 1'b1);
      chk("ip7_lag", cause_o[15], 1'b0);
      tick(1);
      chk("ip7_set", cause_o[15], 1'b1);
      mtc0(5'd11, 32'd5);
      chk("timer_clr", timer_int_o, 1'b0);
      tick(1);
      chk("ip7_clr", cause_o[15], 1'b0);
      mtc0(5'd11, 32'hF000_0000);
      mtc0(5'd12, 32'h0000_0401);
      chk("status_wr", status_o, 32'h0000_0401);
      intr[0] = 1'b1;
      tick(1);
      intr[0] = 1'b0;
      chk("ip2_e1", cause_o[10], 1'b0);
      tick(1);
      chk("ip2_e2", cause_o[10], 1'b0);
      chk("irq_e2", int_req_o, 1'b0);
      tick(1);
      chk("ip2_e3", cause_o[10], 1'b1);
      chk("irq_e3", int_req_o, 1'b1);
      intr[0] = 1'b1;
      tick(3);
      chk("irq_held", int_req_o, 1'b1);
      mtc0(5'd12, 32'h0000_0403);
      chk("irq_exl", int_req_o, 1'b0);
      intr[0] = 1'b0;
      mtc0(5'd12, 32'h0);
      tick(3);
      exc = 1'b1; code = 5'h04; pc = 32'hBFC0_0104; dslot = 1'b1; bad_we = 1'b1; bad_addr = 32'h3;
      tick(1);
      exc = 1'b0; dslot = 1'b0; bad_we = 1'b0;
      chk("ds_epc", epc_o, 32'hBFC0_0100);
      chk("ds_bd", cause_o[31], 1'b1);
      chk("ds_code", cause_o[6:2], 5'h04);
      chk("ds_bad", badvaddr_o, 32'h3);
      chk("ds_exl", status_o[1], 1'b1);
      exc = 1'b1; code = 5'h0C; pc = 32'h8000_0000;
      tick(1);
      exc = 1'b0;
      chk("nest_epc", epc_o, 32'hBFC0_0100);
      chk("nest_bd", cause_o[31], 1'b1);
      chk("nest_code", cause_o[6:2], 5'h0C);
      eret = 1'b1;
      tick(1);
      eret = 1'b0;
      chk("eret_exl", status_o[1], 1'b0);
      we = 1'b1; waddr = 5'd12; data = 32'h0;
      exc = 1'b1; code = 5'h01; pc = 32'h100;
      tick(1);
      we = 1'b0; exc = 1'b0;
      chk("cf_status", status_o, 32'h2);
      chk("cf_epc", epc_o, 32'h100);
      chk("cf_cause", cause_o, 32'h0000_0004);
      mtc0(5'd13, 32'hFFFF_FFFF);
      chk("cause_mask", cause_o, 32'h0080_0304);
      raddr = 5'd3;
      #1;
      chk("rd_unmapped", data_o, 32'h0);
      raddr = 5'd13;
      #1;
      chk("rd_cause", data_o, 32'h0080_0304);
      chk("irq_ie0", int_req_o, 1'b0);
      rst = 1'b0;
      tick(1);
      chk("mid_status", status_o, 32'h1000_0000);
      chk("mid_cause", cause_o, 32'h0);
      chk("mid_epc", epc_o, 32'h0);
      chk("mid_data", data_o, 32'h0);
      rst = 1'b1;
      ms = 32'h1000_0000; mc = '0; me = '0; mb = '0; mcmp = '0; mbase = '0; t = 0;
      for (int i = 0; i < 400; i++) begin
         we = 1'($urandom_range(0, 1));
         waddr = wtab[$urandom_range(0, 6)];
         data = $urandom;
         if (waddr == 5'd9) data[31] = 1'b0;
         if (waddr == 5'd11) data[31:30] = 2'b11;
         raddr = rtab[$urandom_range(0, 9)];
         exc = ($urandom_range(0, 7) == 0);
         eret = ($urandom_range(0, 7) == 0);
         code = 5'($urandom);
         pc = $urandom;
         dslot = 1'($urandom_range(0, 1));
         bad_we = 1'($urandom_range(0, 1));
         bad_addr = $urandom;
         #1;
         chk("rnd_read", data_o, mread(raddr));
         chk("rnd_irq", int_req_o, mirq());
         @(posedge clk);
         model_step();
         #1;
      end
      we = 1'b0; exc = 1'b0; eret = 1'b0;
      chk("end_status", status_o, ms);
      chk("end_cause", cause_o, mc);
      chk("end_epc", epc_o, me);
      chk("end_bad", badvaddr_o, mb);
      chk("end_compare", compare_o, mcmp);
      chk("end_count", count_o, mbase + 32'(t / 3));
      chk("end_config", config_o, 32'h0000_8000);
      $display("test done: total=%0d bad=%0d", ntotal, nbad);
      $finish;
   end
endmodule
